pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Program-counter register and instruction-fetch sequencer for the single-issue CPU.
//   Downstream consumer of the jump/branch left-shifters:
//     - takes the already <<2 jump address;
//     - takes the already <<2 branch offset;
//     - forms the next PC from them.
//   Drives a req/ack fetch handshake to instruction memory.
//   Presents each fetched word to decode with a valid flag and a stall back-pressure input.
// PARAMETERS
//   W         32     datapath/address width in bits
//   RESET_PC  32'h0  PC value loaded on reset
//   STEP      4      sequential PC increment in bytes
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-high reset
//   stall          in   1   decode cannot accept; hold the issued instruction
//   jump_en        in   1   redirect to jump target (sampled in ISSUE only)
//   jump_addr_sh   in   W   jump shifter output; only bits [27:0] are used
//   branch_taken   in   1   redirect to branch target (sampled in ISSUE only)
//   branch_off_sh  in   W   sign-extended branch offset, already <<2
//   imem_req       out  1   fetch request to instruction memory
//   imem_addr      out  W   fetch address; equals pc
//   imem_ack       in   1   memory returns imem_rdata this cycle
//   imem_rdata     in   W   fetched instruction word
//   instr          out  W   instruction presented to decode
//   instr_valid    out  1   instr is valid for decode
//   pc             out  W   current PC register
// BEHAVIOUR
//   Reset (async, any state):
//     - pc = RESET_PC, instr = 0, instr_valid = 0, imem_req = 0;
//     - state = IDLE.
//   FSM states: IDLE -> REQ -> ISSUE -> REQ ...
//   IDLE:
//     - outputs idle;
//     - go to REQ on the next clk unconditionally; stall is ignored.
//   REQ:
//     - imem_req = 1, imem_addr = pc; both held stable until imem_ack.
//     - stall does not withdraw the request.
//     - On imem_ack: instr <= imem_rdata, instr_valid <= 1, pc <= pc + STEP, go to ISSUE.
//     - Fetch latency is 1 clk after ack.
//   ISSUE:
//     - imem_req = 0, instr_valid = 1.
//     - If stall: hold instr, instr_valid and pc.
//     - Else go to REQ, with the pc update chosen by priority:
//         jump_en       : pc <= {pc[W-1:28], jump_addr_sh[27:0]}   (pc here is already old+STEP)
//         branch_taken  : pc <= pc + branch_off_sh                 (mod 2^W)
//         otherwise     : pc unchanged
//     - jump_en and branch_taken both high -> jump wins.
//     - Leaving ISSUE drops instr_valid to 0 on the same edge; instr retains its value.
//   jump_en/branch_taken outside ISSUE, or during stall: ignored, no state change.
//   Arithmetic:
//     - all adds are W-bit unsigned with wrap;
//     - pc = 32'hFFFF_FFFC + STEP -> 32'h0000_0000;
//     - no overflow flag.
//   imem_ack while not in REQ: ignored.
//   Reset asserted mid-REQ: imem_req falls immediately (async); no ack is consumed afterwards.
//   One outstanding fetch at most; no prefetch, no buffering beyond instr.
// STRUCTURE
//   Shared package/header cpu_defs:
//     - FSM state encodings S_IDLE=2'd0, S_REQ=2'd1, S_ISSUE=2'd2;
//     - PC_STEP = 4;
//     - default RESET_PC.
//   One combinational sub-module pc_next_calc(pc, jump_en, jump_addr_sh, branch_taken,
//     branch_off_sh -> pc_next) holds the priority mux and adders.
//   This module holds the FSM, pc, instr and instr_valid registers.
// TESTING
//   1 Reset, release -> pc=0, imem_req=0; next clk imem_req=1, imem_addr=0.
//   2 Ack with rdata=32'h0800_0023 -> next clk instr=32'h0800_0023, instr_valid=1, pc=4.
//   3 ISSUE with jump_en=1, jump_addr_sh=32'h0000_008C -> next request imem_addr=32'h0000_008C.
//   4 ISSUE at pc=32'h90, branch_taken=1, branch_off_sh=32'h0000_013C
//     -> next imem_addr=32'h0000_01CC.
//     Same cycle with jump_en=1, jump_addr_sh=32'h4 -> 32'h0000_0004.
//   5 stall=1 for 3 clks in ISSUE -> instr and pc constant, no imem_req.
//     Withhold ack for 5 clks in REQ -> imem_req and imem_addr stable throughout.
//   6 RESET_PC=32'hFFFF_FFFC, ack -> pc=0 (wrap).
//     Assert reset mid-REQ -> imem_req=0 with no clk edge; pc back to RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU fetch definitions: FSM encodings, the sequential PC step and the default reset PC.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_t;

    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of control, instruction-memory and decode signals around the fetch unit.
interface pc_fetch_if #(
    parameter int W = 32
) ();

    // imem_req/imem_ack: imem_req and imem_addr stay stable from the cycle
    // imem_req rises until the edge where imem_ack is seen high; imem_rdata is
    // valid only in that ack cycle, and an ack without a request is ignored.
    logic         stall;
    logic         jump_en;
    logic [W-1:0] jump_addr_sh;
    logic         branch_taken;
    logic [W-1:0] branch_off_sh;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack;
    logic [W-1:0] imem_rdata;
    logic [W-1:0] instr;
    logic         instr_valid;
    logic [W-1:0] pc;
    logic [1:0]   dbg_state;

    modport master (
        input  stall, jump_en, jump_addr_sh, branch_taken, branch_off_sh,
        input  imem_ack, imem_rdata,
        output imem_req, imem_addr, instr, instr_valid, pc, dbg_state
    );

    modport slave (
        output stall, jump_en, jump_addr_sh, branch_taken, branch_off_sh,
        output imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr, instr_valid, pc, dbg_state
    );

endinterface

// File: rtl/pc_fetch_unit_pc_next_calc.sv
// Redirect target selection: jump beats branch, otherwise the PC is left as is.
module pc_next_calc #(
    parameter int W = 32
) (
    input  logic [W-1:0] pc,
    input  logic         jump_en,
    input  logic [W-1:0] jump_addr_sh,
    input  logic         branch_taken,
    input  logic [W-1:0] branch_off_sh,
    output logic [W-1:0] pc_next
);

    // The jump shifter only ever supplies a 28-bit in-region target.
    logic unused_jump_hi;
    assign unused_jump_hi = ^jump_addr_sh[W-1:28];

    always_comb begin
        pc_next = pc;
        if (jump_en) begin
            pc_next = {pc[W-1:28], jump_addr_sh[27:0]};
        end else if (branch_taken) begin
            pc_next = pc + branch_off_sh;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding fetch sequencer (IDLE -> REQ -> ISSUE -> REQ ...).
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int             W        = 32,
    parameter logic [W-1:0]   RESET_PC = W'(DEFAULT_RESET_PC),
    parameter int             STEP     = PC_STEP
) (
    input  logic       clk,
    input  logic       reset,
    pc_fetch_if.master bus
);

    fetch_state_t state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic [W-1:0] pc_redirect;

    pc_next_calc #(.W(W)) u_pc_next_calc (
        .pc            (pc_q),
        .jump_en       (bus.jump_en),
        .jump_addr_sh  (bus.jump_addr_sh),
        .branch_taken  (bus.branch_taken),
        .branch_off_sh (bus.branch_off_sh),
        .pc_next       (pc_redirect)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (bus.imem_ack) state_d = S_ISSUE;
            S_ISSUE: if (!bus.stall) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req    = (state_q == S_REQ);
        bus.imem_addr   = pc_q;
        bus.instr       = instr_q;
        bus.instr_valid = instr_valid_q;
        bus.pc          = pc_q;
        bus.dbg_state   = state_q;
    end

    // Redirect inputs only matter on the edge that leaves ISSUE.
    always_comb begin
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        if (state_q == S_REQ && bus.imem_ack) begin
            instr_d       = bus.imem_rdata;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + W'(STEP);
        end else if (state_q == S_ISSUE && !bus.stall) begin
            instr_valid_d = 1'b0;
            pc_d          = pc_redirect;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: chained fetch/redirect table plus stall, ack-hold, wrap and reset sequences.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    int checks   = 0;
    int failures = 0;

    pc_fetch_if #(.W(32)) if0 ();
    pc_fetch_if #(.W(32)) if1 ();

    pc_fetch_unit #(.W(32), .RESET_PC(32'h0000_0000), .STEP(4)) dut0 (
        .clk(clk), .reset(rst0), .bus(if0)
    );
    pc_fetch_unit #(.W(32), .RESET_PC(32'hFFFF_FFFC), .STEP(4)) dut1 (
        .clk(clk), .reset(rst1), .bus(if1)
    );

    typedef struct {
        logic [31:0] fetch_addr;
        logic [31:0] rdata;
        int          ack_delay;
        logic        jump_en;
        logic [31:0] jump_addr;
        logic        br;
        logic [31:0] off;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs0();
        if0.stall = 1'b0; if0.jump_en = 1'b0; if0.jump_addr_sh = '0;
        if0.branch_taken = 1'b0; if0.branch_off_sh = '0;
        if0.imem_ack = 1'b0; if0.imem_rdata = '0;
    endtask

    initial begin
        // fetch_addr, rdata, ack_delay, jump_en, jump_addr, branch, off, expected next fetch
        vecs[0] = '{32'h0000_0000, 32'h0800_0023, 0, 1'b1, 32'h0000_008C, 1'b0, 32'h0000_0000, 32'h0000_008C};
        vecs[1] = '{32'h0000_008C, 32'h1111_0001, 2, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_013C, 32'h0000_01CC};
        vecs[2] = '{32'h0000_01CC, 32'h2222_0002, 0, 1'b1, 32'h0000_008C, 1'b0, 32'h0000_0000, 32'h0000_008C};
        vecs[3] = '{32'h0000_008C, 32'h3333_0003, 1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_013C, 32'h0000_0004};
        vecs[4] = '{32'h0000_0004, 32'h4444_0004, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0008};
        vecs[5] = '{32'h0000_0008, 32'h5555_0005, 3, 1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFF4, 32'h0000_0000};
        vecs[6] = '{32'h0000_0000, 32'h6666_0006, 0, 1'b1, 32'hF123_4568, 1'b0, 32'h0000_0000, 32'h0123_4568};
        vecs[7] = '{32'h0123_4568, 32'h7777_0007, 1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0100, 32'h0123_466C};
        vecs[8] = '{32'h0123_466C, 32'h8888_0008, 0, 1'b0, 32'h0000_0000, 1'b1, 32'h3000_0000, 32'h3123_4670};
        vecs[9] = '{32'h3123_4670, 32'h9999_0009, 0, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0000, 32'h3000_0040};

        clear_inputs0();
        if1.stall = 1'b0; if1.jump_en = 1'b0; if1.jump_addr_sh = '0;
        if1.branch_taken = 1'b0; if1.branch_off_sh = '0;
        if1.imem_ack = 1'b0; if1.imem_rdata = '0;
        rst0 = 1'b1;
        rst1 = 1'b1;

        // Reset state, then first request
        tick(); tick();
        chk("rst_pc", if0.pc, 32'h0);
        chk("rst_req", 32'(if0.imem_req), 32'h0);
        chk("rst_valid", 32'(if0.instr_valid), 32'h0);
        chk("rst_instr", if0.instr, 32'h0);
        chk("rst_state", 32'(if0.dbg_state), 32'(S_IDLE));
        rst0 = 1'b0;
        #1;
        chk("rel_req", 32'(if0.imem_req), 32'h0);
        if0.stall = 1'b1;
        tick();
        if0.stall = 1'b0;
        chk("first_req", 32'(if0.imem_req), 32'h1);
        chk("first_addr", if0.imem_addr, 32'h0);

        // Chained fetch / redirect table
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("v%0d_addr", i), if0.imem_addr, vecs[i].fetch_addr);
            chk($sformatf("v%0d_req", i), 32'(if0.imem_req), 32'h1);
            for (int d = 0; d < vecs[i].ack_delay; d++) begin
                if0.jump_en = 1'b1; if0.jump_addr_sh = 32'h0555_5550;
                if0.branch_taken = 1'b1; if0.branch_off_sh = 32'h0000_1000;
                if0.stall = 1'b1;
                tick();
                chk($sformatf("v%0d_hold_addr", i), if0.imem_addr, vecs[i].fetch_addr);
                chk($sformatf("v%0d_hold_req", i), 32'(if0.imem_req), 32'h1);
            end
            clear_inputs0();
            if0.imem_ack = 1'b1;
            if0.imem_rdata = vecs[i].rdata;
            tick();
            if0.imem_ack = 1'b0;
            if0.imem_rdata = 32'hDEAD_BEEF;
            chk($sformatf("v%0d_instr", i), if0.instr, vecs[i].rdata);
            chk($sformatf("v%0d_valid", i), 32'(if0.instr_valid), 32'h1);
            chk($sformatf("v%0d_pc", i), if0.pc, vecs[i].fetch_addr + 32'd4);
            chk($sformatf("v%0d_req_lo", i), 32'(if0.imem_req), 32'h0);
            if0.jump_en = vecs[i].jump_en;
            if0.jump_addr_sh = vecs[i].jump_addr;
            if0.branch_taken = vecs[i].br;
            if0.branch_off_sh = vecs[i].off;
            tick();
            clear_inputs0();
            chk($sformatf("v%0d_next", i), if0.imem_addr, vecs[i].exp_next);
            chk($sformatf("v%0d_next_req", i), 32'(if0.imem_req), 32'h1);
            chk($sformatf("v%0d_valid_lo", i), 32'(if0.instr_valid), 32'h0);
            chk($sformatf("v%0d_instr_kept", i), if0.instr, vecs[i].rdata);
        end

        // Withhold ack for 5 clocks in REQ
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("wait_req", 32'(if0.imem_req), 32'h1);
            chk("wait_addr", if0.imem_addr, 32'h3000_0040);
        end
        if0.imem_ack = 1'b1;
        if0.imem_rdata = 32'h0000_ABCD;
        tick();

        // Stall 3 clocks in ISSUE; redirect and stray ack must be ignored
        if0.stall = 1'b1;
        if0.jump_en = 1'b1; if0.jump_addr_sh = 32'h0000_0100;
        if0.imem_ack = 1'b1; if0.imem_rdata = 32'h1357_9BDF;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_instr", if0.instr, 32'h0000_ABCD);
            chk("stall_pc", if0.pc, 32'h3000_0044);
            chk("stall_req", 32'(if0.imem_req), 32'h0);
            chk("stall_valid", 32'(if0.instr_valid), 32'h1);
        end
        clear_inputs0();
        tick();
        chk("unstall_req", 32'(if0.imem_req), 32'h1);
        chk("unstall_addr", if0.imem_addr, 32'h3000_0044);
        chk("unstall_valid", 32'(if0.instr_valid), 32'h0);

        // Wrap from RESET_PC = FFFF_FFFC
        chk("w_rst_pc", if1.pc, 32'hFFFF_FFFC);
        rst1 = 1'b0;
        tick();
        chk("w_req", 32'(if1.imem_req), 32'h1);
        chk("w_addr", if1.imem_addr, 32'hFFFF_FFFC);
        if1.imem_ack = 1'b1;
        if1.imem_rdata = 32'h0000_1234;
        tick();
        if1.imem_ack = 1'b0;
        chk("w_pc", if1.pc, 32'h0000_0000);
        chk("w_instr", if1.instr, 32'h0000_1234);
        tick();
        chk("w_next_addr", if1.imem_addr, 32'h0000_0000);
        chk("w_next_req", 32'(if1.imem_req), 32'h1);

        // Asynchronous reset mid-REQ, with ack held high across release
        #2;
        if1.imem_ack = 1'b1;
        if1.imem_rdata = 32'hCAFE_0000;
        rst1 = 1'b1;
        #1;
        chk("ar_req", 32'(if1.imem_req), 32'h0);
        chk("ar_pc", if1.pc, 32'hFFFF_FFFC);
        chk("ar_valid", 32'(if1.instr_valid), 32'h0);
        chk("ar_instr", if1.instr, 32'h0);
        tick();
        rst1 = 1'b0;
        tick();
        chk("ar_post_state", 32'(if1.dbg_state), 32'(S_REQ));
        chk("ar_post_instr", if1.instr, 32'h0);
        chk("ar_post_pc", if1.pc, 32'hFFFF_FFFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
